// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared encodings for the MIPS core's MEM pipeline stage.
// Revision : 1.0
// ============================================================================
package mips_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/memory_load_align.sv
`default_nettype none
// ============================================================================
// Module   : load_align
// Brief    : Picks the addressed lane of a 32-bit load word and extends it.
// Revision : 1.0
// ============================================================================
module load_align
    import mips_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        // Little-endian lanes: address offset 0 is the least significant byte.
        case (addr_lo)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SIZE_BYTE: data = {{24{sign & w_byte[7]}}, w_byte};
            SIZE_HALF: data = {{16{sign & w_half[15]}}, w_half};
            default:   data = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/memory.sv
`default_nettype none
// ============================================================================
// Module   : memory
// Brief    : MEM stage - issues aligned data-memory accesses, stalls on wait
//            states, aligns load data and registers the MEM/WB fields.
// Revision : 1.0
// ============================================================================
module memory
    import mips_pkg::*;
#(
    parameter int ADDR_SIZE  = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_mem,
    input  logic [DATA_WIDTH-1:0] alu_data_mem,
    input  logic [DATA_WIDTH-1:0] store_data_mem,
    input  logic                  mem_re_mem,
    input  logic                  mem_we_mem,
    input  logic [1:0]            mem_size_mem,
    input  logic                  mem_sign_mem,
    input  logic                  reg_d_we_mem,
    input  logic [ADDR_SIZE-1:0]  reg_d_addr_mem,
    input  logic                  reg_d_data_sel_mem,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  mem_stall,
    output logic                  mem_misaligned,
    output logic [DATA_WIDTH-1:0] alu_data_wb,
    output logic [DATA_WIDTH-1:0] mem_data_wb,
    output logic                  reg_d_we_wb,
    output logic [ADDR_SIZE-1:0]  reg_d_addr_wb,
    output logic                  reg_d_data_sel_wb
);

    mem_state_t      r_state;
    logic            w_aligned;
    logic            w_is_mem;
    logic            w_access;
    logic            w_misaligned;
    logic [1:0]      w_lo;
    logic [31:0]     w_load_data;

    assign w_lo     = alu_data_mem[1:0];
    assign w_is_mem = valid_mem & (mem_re_mem | mem_we_mem);

    always_comb begin
        case (mem_size_mem)
            SIZE_BYTE: w_aligned = 1'b1;
            SIZE_HALF: w_aligned = ~w_lo[0];
            default:   w_aligned = (w_lo == 2'b00);
        endcase
    end

    assign w_access     = w_is_mem & w_aligned;
    assign w_misaligned = w_is_mem & ~w_aligned;

    // WAIT relies on upstream holding the MEM inputs, so the request fields
    // are recomputed from them and stay identical until the ack.
    assign dmem_req       = ~rst & ((r_state == MEM_WAIT) | w_access);
    assign dmem_we        = dmem_req & mem_we_mem;
    assign dmem_addr      = {alu_data_mem[DATA_WIDTH-1:2], 2'b00};
    assign mem_stall      = dmem_req & ~dmem_ack;
    assign mem_misaligned = w_misaligned;

    always_comb begin
        case (mem_size_mem)
            SIZE_BYTE: begin
                dmem_be    = 4'b0001 << w_lo;
                dmem_wdata = {4{store_data_mem[7:0]}};
            end
            SIZE_HALF: begin
                dmem_be    = 4'b0011 << w_lo;
                dmem_wdata = {2{store_data_mem[15:0]}};
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = store_data_mem;
            end
        endcase
    end

    load_align u_load_align (
        .addr_lo (w_lo),
        .size    (mem_size_mem),
        .sign    (mem_sign_mem),
        .rdata   (dmem_rdata),
        .data    (w_load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MEM_IDLE;
        end else begin
            case (r_state)
                MEM_IDLE: if (w_access && !dmem_ack) r_state <= MEM_WAIT;
                MEM_WAIT: if (dmem_ack) r_state <= MEM_IDLE;
                default:  r_state <= MEM_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_data_wb       <= '0;
            mem_data_wb       <= '0;
            reg_d_we_wb       <= 1'b0;
            reg_d_addr_wb     <= '0;
            reg_d_data_sel_wb <= 1'b0;
        end else if (mem_stall) begin
            reg_d_we_wb <= 1'b0;
        end else begin
            alu_data_wb       <= alu_data_mem;
            mem_data_wb       <= (w_access & mem_re_mem) ? w_load_data : '0;
            reg_d_we_wb       <= valid_mem & reg_d_we_mem & ~w_misaligned;
            reg_d_addr_wb     <= reg_d_addr_mem;
            reg_d_data_sel_wb <= reg_d_data_sel_mem;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory
// Brief    : Directed self-checking bench for the MEM pipeline stage.
// Revision : 1.0
// ============================================================================
module tb_memory;
    import mips_pkg::*;

    logic        clk;
    logic        rst;
    logic        valid_mem;
    logic [31:0] alu_data_mem;
    logic [31:0] store_data_mem;
    logic        mem_re_mem;
    logic        mem_we_mem;
    logic [1:0]  mem_size_mem;
    logic        mem_sign_mem;
    logic        reg_d_we_mem;
    logic [4:0]  reg_d_addr_mem;
    logic        reg_d_data_sel_mem;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic        mem_misaligned;
    logic [31:0] alu_data_wb;
    logic [31:0] mem_data_wb;
    logic        reg_d_we_wb;
    logic [4:0]  reg_d_addr_wb;
    logic        reg_d_data_sel_wb;

    int vectors = 0;
    int miscompares = 0;
    int handshakes = 0;

    memory #(.ADDR_SIZE(5), .DATA_WIDTH(32)) dut (
        .clk                (clk),
        .rst                (rst),
        .valid_mem          (valid_mem),
        .alu_data_mem       (alu_data_mem),
        .store_data_mem     (store_data_mem),
        .mem_re_mem         (mem_re_mem),
        .mem_we_mem         (mem_we_mem),
        .mem_size_mem       (mem_size_mem),
        .mem_sign_mem       (mem_sign_mem),
        .reg_d_we_mem       (reg_d_we_mem),
        .reg_d_addr_mem     (reg_d_addr_mem),
        .reg_d_data_sel_mem (reg_d_data_sel_mem),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_be            (dmem_be),
        .dmem_wdata         (dmem_wdata),
        .dmem_ack           (dmem_ack),
        .dmem_rdata         (dmem_rdata),
        .mem_stall          (mem_stall),
        .mem_misaligned     (mem_misaligned),
        .alu_data_wb        (alu_data_wb),
        .mem_data_wb        (mem_data_wb),
        .reg_d_we_wb        (reg_d_we_wb),
        .reg_d_addr_wb      (reg_d_addr_wb),
        .reg_d_data_sel_wb  (reg_d_data_sel_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Completed memory transactions, counted independently of the DUT state.
    always @(posedge clk) if (dmem_req && dmem_ack) handshakes = handshakes + 1;

    task automatic set_op(input logic v, input logic [31:0] a, input logic [31:0] sd,
                          input logic re, input logic we, input logic [1:0] sz,
                          input logic sg, input logic rwe, input logic [4:0] ra,
                          input logic sel);
        valid_mem = v; alu_data_mem = a; store_data_mem = sd; mem_re_mem = re;
        mem_we_mem = we; mem_size_mem = sz; mem_sign_mem = sg; reg_d_we_mem = rwe;
        reg_d_addr_mem = ra; reg_d_data_sel_mem = sel;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
        set_op(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, SIZE_WORD, 1'b0, 1'b0, 5'd0, 1'b0);
        tick(); tick();
        vectors++; if ({alu_data_wb, mem_data_wb, reg_d_we_wb, reg_d_addr_wb, reg_d_data_sel_wb} !== '0) begin
            miscompares++; $display("FAIL reset_wb: got alu=%h mem=%h we=%b", alu_data_wb, mem_data_wb, reg_d_we_wb); end
        vectors++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
            miscompares++; $display("FAIL reset_req: req=%b stall=%b want 0/0", dmem_req, mem_stall); end
        rst = 1'b0;
    endtask

    task automatic test_lw_zero_wait;
        set_op(1'b1, 32'h104, 32'h0, 1'b1, 1'b0, SIZE_WORD, 1'b0, 1'b1, 5'd5, 1'b1);
        dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
        #1;
        vectors++; if ({dmem_req, mem_stall, dmem_we, dmem_addr, dmem_be} !== {1'b1, 1'b0, 1'b0, 32'h104, 4'b1111}) begin
            miscompares++; $display("FAIL lw_req: req=%b stall=%b we=%b addr=%h be=%b want 1 0 0 00000104 1111", dmem_req, mem_stall, dmem_we, dmem_addr, dmem_be); end
        tick();
        vectors++; if ({mem_data_wb, reg_d_data_sel_wb, reg_d_we_wb, reg_d_addr_wb} !== {32'hDEADBEEF, 1'b1, 1'b1, 5'd5}) begin
            miscompares++; $display("FAIL lw_wb: mem=%h sel=%b we=%b rd=%0d want deadbeef 1 1 5", mem_data_wb, reg_d_data_sel_wb, reg_d_we_wb, reg_d_addr_wb); end
    endtask

    task automatic test_lb_wait(input logic sg, input logic [31:0] expect_data);
        set_op(1'b1, 32'h103, 32'h0, 1'b1, 1'b0, SIZE_BYTE, sg, 1'b1, 5'd9, 1'b1);
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if ({mem_stall, dmem_req, dmem_be} !== {1'b1, 1'b1, 4'b1000}) begin
                miscompares++; $display("FAIL lb_stall%0d: stall=%b req=%b be=%b want 1 1 1000", i, mem_stall, dmem_req, dmem_be); end
            tick();
            vectors++; if (reg_d_we_wb !== 1'b0) begin
                miscompares++; $display("FAIL lb_bubble%0d: we_wb=%b want 0", i, reg_d_we_wb); end
        end
        dmem_ack = 1'b1; dmem_rdata = 32'h80123456;
        #1;
        vectors++; if ({mem_stall, dmem_req} !== 2'b01) begin
            miscompares++; $display("FAIL lb_ack: stall=%b req=%b want 0 1", mem_stall, dmem_req); end
        tick();
        vectors++; if ({mem_data_wb, reg_d_we_wb, reg_d_addr_wb} !== {expect_data, 1'b1, 5'd9}) begin
            miscompares++; $display("FAIL lb_data: mem=%h we=%b rd=%0d want %h 1 9", mem_data_wb, reg_d_we_wb, reg_d_addr_wb, expect_data); end
    endtask

    task automatic test_sh;
        set_op(1'b1, 32'h202, 32'h0000ABCD, 1'b0, 1'b1, SIZE_HALF, 1'b0, 1'b0, 5'd0, 1'b0);
        dmem_ack = 1'b1;
        #1;
        vectors++; if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !== {1'b1, 1'b1, 32'h200, 4'b1100, 32'hABCDABCD}) begin
            miscompares++; $display("FAIL sh_req: req=%b we=%b addr=%h be=%b wdata=%h want 1 1 00000200 1100 abcdabcd", dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata); end
        tick();
        vectors++; if ({reg_d_we_wb, mem_data_wb} !== {1'b0, 32'h0}) begin
            miscompares++; $display("FAIL sh_wb: we=%b mem=%h want 0 00000000", reg_d_we_wb, mem_data_wb); end
        set_op(1'b1, 32'h3, 32'h000000A5, 1'b0, 1'b1, SIZE_BYTE, 1'b0, 1'b0, 5'd0, 1'b0);
        #1;
        vectors++; if ({dmem_be, dmem_wdata} !== {4'b1000, 32'hA5A5A5A5}) begin
            miscompares++; $display("FAIL sb_lanes: be=%b wdata=%h want 1000 a5a5a5a5", dmem_be, dmem_wdata); end
        tick();
    endtask

    task automatic test_misaligned;
        set_op(1'b1, 32'h101, 32'h0, 1'b1, 1'b0, SIZE_WORD, 1'b0, 1'b1, 5'd6, 1'b1);
        dmem_ack = 1'b0;
        #1;
        vectors++; if ({mem_misaligned, dmem_req, mem_stall} !== 3'b100) begin
            miscompares++; $display("FAIL misalign: mis=%b req=%b stall=%b want 1 0 0", mem_misaligned, dmem_req, mem_stall); end
        tick();
        vectors++; if (reg_d_we_wb !== 1'b0) begin
            miscompares++; $display("FAIL misalign_wb: we_wb=%b want 0", reg_d_we_wb); end
        set_op(1'b1, 32'h106, 32'h0, 1'b1, 1'b0, SIZE_HALF, 1'b0, 1'b1, 5'd6, 1'b1);
        dmem_ack = 1'b1;
        #1;
        vectors++; if ({mem_misaligned, dmem_req, dmem_be} !== {1'b0, 1'b1, 4'b1100}) begin
            miscompares++; $display("FAIL half_aligned: mis=%b req=%b be=%b want 0 1 1100", mem_misaligned, dmem_req, dmem_be); end
        tick();
    endtask

    task automatic test_reset_in_wait;
        set_op(1'b1, 32'h104, 32'h0, 1'b1, 1'b0, SIZE_WORD, 1'b0, 1'b1, 5'd2, 1'b1);
        dmem_ack = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        vectors++; if ({dmem_req, mem_stall} !== 2'b00) begin
            miscompares++; $display("FAIL rst_wait_req: req=%b stall=%b want 0 0", dmem_req, mem_stall); end
        vectors++; if ({alu_data_wb, mem_data_wb, reg_d_we_wb, reg_d_addr_wb, reg_d_data_sel_wb} !== '0) begin
            miscompares++; $display("FAIL rst_wait_wb: alu=%h mem=%h we=%b rd=%0d want all 0", alu_data_wb, mem_data_wb, reg_d_we_wb, reg_d_addr_wb); end
        set_op(1'b1, 32'h5, 32'h0, 1'b0, 1'b0, SIZE_WORD, 1'b0, 1'b1, 5'd3, 1'b0);
        #1;
        rst = 1'b0;
        tick();
        vectors++; if ({alu_data_wb, reg_d_addr_wb, reg_d_we_wb, reg_d_data_sel_wb} !== {32'h5, 5'd3, 1'b1, 1'b0}) begin
            miscompares++; $display("FAIL rst_after: alu=%h rd=%0d we=%b sel=%b want 5 3 1 0", alu_data_wb, reg_d_addr_wb, reg_d_we_wb, reg_d_data_sel_wb); end
    endtask

    task automatic test_back_to_back;
        int hs0;
        hs0 = handshakes;
        // add with a stray ack: no request must be issued
        set_op(1'b1, 32'h11, 32'h0, 1'b0, 1'b0, SIZE_WORD, 1'b0, 1'b1, 5'd4, 1'b0);
        dmem_ack = 1'b1;
        #1;
        vectors++; if ({dmem_req, mem_stall} !== 2'b00) begin
            miscompares++; $display("FAIL b2b_add_req: req=%b stall=%b want 0 0", dmem_req, mem_stall); end
        tick();
        vectors++; if ({alu_data_wb, reg_d_we_wb, reg_d_addr_wb} !== {32'h11, 1'b1, 5'd4}) begin
            miscompares++; $display("FAIL b2b_add: alu=%h we=%b rd=%0d want 11 1 4", alu_data_wb, reg_d_we_wb, reg_d_addr_wb); end
        set_op(1'b1, 32'h40, 32'h12345678, 1'b0, 1'b1, SIZE_WORD, 1'b0, 1'b0, 5'd0, 1'b0);
        dmem_ack = 1'b0;
        #1;
        vectors++; if ({dmem_req, dmem_we, mem_stall, dmem_wdata} !== {1'b1, 1'b1, 1'b1, 32'h12345678}) begin
            miscompares++; $display("FAIL b2b_sw_req: req=%b we=%b stall=%b wdata=%h want 1 1 1 12345678", dmem_req, dmem_we, mem_stall, dmem_wdata); end
        tick();
        vectors++; if (reg_d_we_wb !== 1'b0) begin
            miscompares++; $display("FAIL b2b_bubble: we_wb=%b want 0", reg_d_we_wb); end
        dmem_ack = 1'b1;
        tick();
        vectors++; if ({alu_data_wb, reg_d_we_wb, mem_data_wb} !== {32'h40, 1'b0, 32'h0}) begin
            miscompares++; $display("FAIL b2b_sw: alu=%h we=%b mem=%h want 40 0 0", alu_data_wb, reg_d_we_wb, mem_data_wb); end
        set_op(1'b1, 32'h44, 32'h0, 1'b1, 1'b0, SIZE_WORD, 1'b0, 1'b1, 5'd7, 1'b1);
        dmem_rdata = 32'hCAFEF00D;
        tick();
        vectors++; if ({alu_data_wb, mem_data_wb, reg_d_we_wb, reg_d_addr_wb, reg_d_data_sel_wb} !== {32'h44, 32'hCAFEF00D, 1'b1, 5'd7, 1'b1}) begin
            miscompares++; $display("FAIL b2b_lw: alu=%h mem=%h we=%b rd=%0d sel=%b want 44 cafef00d 1 7 1", alu_data_wb, mem_data_wb, reg_d_we_wb, reg_d_addr_wb, reg_d_data_sel_wb); end
        set_op(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, SIZE_WORD, 1'b0, 1'b0, 5'd0, 1'b0);
        #1;
        vectors++; if (dmem_req !== 1'b0) begin
            miscompares++; $display("FAIL b2b_invalid: req=%b want 0", dmem_req); end
        tick();
        vectors++; if (handshakes - hs0 !== 2) begin
            miscompares++; $display("FAIL b2b_count: handshakes=%0d want 2", handshakes - hs0); end
    endtask

    initial begin
        test_reset();
        test_lw_zero_wait();
        test_lb_wait(1'b1, 32'hFFFFFF80);
        test_lb_wait(1'b0, 32'h00000080);
        test_sh();
        test_misaligned();
        test_reset_in_wait();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
